// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - chunked multi-cycle adder with valid/ready handshake on both sides
// Define SERIAL_ADDER_SUB_EN to add the sub port (A + ~B + 1 when sub=1).
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADD  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [KW-1:0]    k;
   logic             carry;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic [WIDTH-1:0] b_eff;
   logic             carry_eff;
   logic [31:0]      base;
   logic [CHUNK-1:0] a_slice;
   logic [CHUNK-1:0] b_slice;
   logic [CHUNK:0]   chunk_total;
   logic             ovf_next;

   // b_q holds the already-inverted operand when subtracting, so ADD never looks at sub
   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      b_eff     = sub ? ~b : b;
      carry_eff = sub ? 1'b1 : cin;
`else
      b_eff     = b;
      carry_eff = cin;
`endif
   end

   assign base        = 32'(k) * 32'(CHUNK);
   assign a_slice     = CHUNK'(a_q >> base);
   assign b_slice     = CHUNK'(b_q >> base);
   assign chunk_total = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};

   // On the last chunk the slice MSB is sum[WIDTH-1]; a^b^s recovers the carry into that bit
   assign ovf_next = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_total[CHUNK-1] ^ chunk_total[CHUNK];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         k      <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q    <= a;
                  b_q    <= b_eff;
                  k      <= '0;
                  carry  <= carry_eff;
                  sum_q  <= '0;
                  cout_q <= 1'b0;
                  ovf_q  <= 1'b0;
                  state  <= ADD;
               end
            end
            ADD: begin
               sum_q <= sum_q | (WIDTH'(chunk_total[CHUNK-1:0]) << base);
               carry <= chunk_total[CHUNK];
               if (k == K_LAST) begin
                  cout_q <= chunk_total[CHUNK];
                  ovf_q  <= ovf_next;
                  state  <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == ADD) || (state == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - vector table, handshake corner cases and randomized model compare for serial_adder
module tb_serial_adder;
`ifdef SERIAL_ADDER_SUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] a_in, b_in;
   logic        cin_in, sub_in, out_ready;
   logic [2:0]  iv, rdy, vld, bsy, co, ov;
   logic [7:0]  sum8;
   logic [0:0]  sum1;
   logic [15:0] sum16;

   int n_pass = 0;
   int n_total = 0;

   serial_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
      .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub_in),
`endif
      .out_valid(vld[0]), .out_ready(out_ready), .sum(sum8),
      .cout(co[0]), .ovf(ov[0]), .busy(bsy[0]));

   serial_adder #(.WIDTH(1), .CHUNK(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
      .a(a_in[0:0]), .b(b_in[0:0]), .cin(cin_in),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub_in),
`endif
      .out_valid(vld[1]), .out_ready(out_ready), .sum(sum1),
      .cout(co[1]), .ovf(ov[1]), .busy(bsy[1]));

   serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]),
      .a(a_in), .b(b_in), .cin(cin_in),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub_in),
`endif
      .out_valid(vld[2]), .out_ready(out_ready), .sum(sum16),
      .cout(co[2]), .ovf(ov[2]), .busy(bsy[2]));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   function automatic logic [15:0] rd_sum(input int d);
      case (d)
         0:       return {8'h00, sum8};
         1:       return {15'h0000, sum1};
         default: return sum16;
      endcase
   endfunction

   // Reference: unsigned total for sum/cout, signed range test for ovf
   task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic c,
                        input logic s, output logic [15:0] es, output logic eco, output logic eov);
      longint m, ua, ub, t, sa, sb, st;
      m  = longint'(1) << w;
      ua = longint'(av) % m;
      ub = longint'(bv) % m;
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (s) begin
         t  = ua + (m - 1 - ub) + 1;
         st = sa - sb;
      end else begin
         t  = ua + ub + longint'(c);
         st = sa + sb + longint'(c);
      end
      es  = 16'(t % m);
      eco = (t >= m);
      eov = (st < -(m / 2)) || (st > m / 2 - 1);
   endtask

   task automatic op(input int d, input logic [15:0] av, input logic [15:0] bv, input logic c,
                     input logic s, input logic [15:0] es, input logic eco, input logic eov,
                     input string nm);
      int n;
      n = 0;
      while (!rdy[d] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, " in_ready"}, rdy[d], 1);
      out_ready = 1'b1;
      a_in = av; b_in = bv; cin_in = c; sub_in = s; iv[d] = 1'b1;
      @(posedge clk); #1;
      iv[d] = 1'b0;
      chk({nm, " busy"}, bsy[d], 1);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!vld[d] && n < 50);
      chk({nm, " latency"}, n, (d == 1) ? 1 : 4);
      chk({nm, " sum"}, rd_sum(d), es);
      chk({nm, " cout"}, co[d], eco);
      chk({nm, " ovf"}, ov[d], eov);
      @(posedge clk); #1;
      chk({nm, " handoff"}, {vld[d], rdy[d]}, 2'b01);
   endtask

   initial begin
      logic [15:0] es, av, bv;
      logic        eco, eov, c, s;
      int          n, seen;

      rst = 1'b1; iv = '0; out_ready = 1'b1;
      a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset%0d sum", d), rd_sum(d), 0);
         chk($sformatf("reset%0d flags", d), {co[d], ov[d], vld[d], bsy[d], rdy[d]}, 5'b00001);
      end

      vecs.push_back(vec_t'{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1});
      vecs.push_back(vec_t'{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
      vecs.push_back(vec_t'{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1});
      vecs.push_back(vec_t'{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
      vecs.push_back(vec_t'{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
      vecs.push_back(vec_t'{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
      vecs.push_back(vec_t'{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
      vecs.push_back(vec_t'{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0});
      vecs.push_back(vec_t'{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
      vecs.push_back(vec_t'{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0});
`endif
      for (int i = 0; i < vecs.size(); i++)
         op(0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].cin, vecs[i].sub,
            {8'h00, vecs[i].s}, vecs[i].co, vecs[i].ov, $sformatf("vec%0d", i));

      // Result held in DONE with out_ready low; in_valid pulse must be ignored
      out_ready = 1'b0;
      a_in = 16'h0011; b_in = 16'h0022; cin_in = 1'b0; sub_in = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("hold out_valid rise", vld[0], 1);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            a_in = 16'h00FF; b_in = 16'h00FF; iv[0] = 1'b1;
         end else begin
            iv[0] = 1'b0;
         end
         @(posedge clk); #1;
         chk($sformatf("hold%0d sum", i), sum8, 8'h33);
         chk($sformatf("hold%0d ready/valid", i), {rdy[0], vld[0]}, 2'b01);
      end
      a_in = 16'h0001; b_in = 16'h0002; cin_in = 1'b1; iv[0] = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("handoff no accept", {rdy[0], vld[0], bsy[0]}, 3'b100);
      chk("idle keeps sum", sum8, 8'h33);
      @(posedge clk); #1;
      iv[0] = 1'b0;
      chk("accept clears sum", {bsy[0], sum8}, {1'b1, 8'h00});
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!vld[0] && n < 50);
      chk("b2b latency", n, 4);
      chk("b2b result", {co[0], ov[0], sum8}, {2'b00, 8'h04});
      @(posedge clk); #1;

      // Reset mid-operation at k=2
      a_in = 16'h005A; b_in = 16'h003C; cin_in = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort outputs", {sum8, co[0], ov[0], vld[0], bsy[0], rdy[0]}, {8'h00, 5'b00001});
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (vld[0]) seen++;
      end
      chk("abort no out_valid", seen, 0);
      op(0, 16'h005A, 16'h003C, 1'b0, 1'b0, 16'h0096, 1'b0, 1'b1, "after abort");

      op(1, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "w1 1+1");
      for (int i = 0; i < (HAS_SUB ? 16 : 8); i++) begin
         av = {15'h0, i[0]}; bv = {15'h0, i[1]}; c = i[2]; s = i[3];
         model(1, av, bv, c, s, es, eco, eov);
         op(1, av, bv, c, s, es, eco, eov, $sformatf("w1 exh%0d", i));
      end

      for (int i = 0; i < 60; i++) begin
         av = 16'($urandom); bv = 16'($urandom);
         c = 1'($urandom_range(0, 1));
         s = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
         model(8, av, bv, c, s, es, eco, eov);
         op(0, av, bv, c, s, es, eco, eov, $sformatf("w8 rnd%0d a=%0h b=%0h c=%0b s=%0b", i, av[7:0], bv[7:0], c, s));
      end

      for (int i = 0; i < 150; i++) begin
         av = 16'($urandom); bv = 16'($urandom);
         c = 1'($urandom_range(0, 1));
         s = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
         model(16, av, bv, c, s, es, eco, eov);
         op(2, av, bv, c, s, es, eco, eov, $sformatf("w16 rnd%0d a=%0h b=%0h c=%0b s=%0b", i, av, bv, c, s));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001: The module SHALL expose parameter WIDTH, default 8, meaning operand and sum width in bits.
REQ-002: The module SHALL expose parameter CHUNK, default 2, meaning bits added per cycle; WIDTH SHALL be a multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003: clk  input  1  single clock; all state changes on the rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: in_valid  input  1  operands offered.
REQ-006: in_ready  output  1  block can accept operands.
REQ-007: a  input  WIDTH  operand A.
REQ-008: b  input  WIDTH  operand B.
REQ-009: cin  input  1  carry-in.
REQ-010: sub  input  1  subtract select; this port is present only with SERIAL_ADDER_SUB_EN.
REQ-011: out_valid  output  1  result available.
REQ-012: out_ready  input  1  consumer takes the result.
REQ-013: sum  output  WIDTH  result.
REQ-014: cout  output  1  carry out of the MSB.
REQ-015: ovf  output  1  signed overflow.
REQ-016: busy  output  1  high in states ADD and DONE.

Function
REQ-017: The FSM SHALL have three states, IDLE, ADD and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-018: In IDLE, when in_valid is high at a clock edge, the block SHALL register a, b and cin (and sub if present), clear the chunk counter and the result register, load the carry register with the effective carry-in, and enter ADD.
REQ-019: In ADD, each cycle SHALL add bits [k*CHUNK +: CHUNK] of A and B' plus the carry register, write that slice of sum, update the carry, and increment k.
REQ-020: After the cycle with k = NCHUNK-1, the block SHALL enter DONE; out_valid SHALL rise exactly NCHUNK clock edges after the accepting edge.
REQ-021: cout SHALL equal the carry out of bit WIDTH-1; ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-022: In DONE, sum, cout and ovf SHALL hold stable while out_ready is low; in_valid SHALL be ignored.
REQ-023: In DONE, with out_ready high at a clock edge, the block SHALL return to IDLE; in_ready SHALL be high in the next cycle; there is no accept in the same cycle as a result handoff.
REQ-024: sum, cout and ovf SHALL keep the last result in IDLE until the next accept clears them.
REQ-025: Arithmetic SHALL be modulo 2^WIDTH, with no saturation.
REQ-026: With WIDTH=1 and CHUNK=1 the block SHALL behave as a registered full adder with 1-cycle latency.

Reset
REQ-027: While rst is high at a clock edge, the block SHALL enter IDLE and clear the counter and carry register; sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 after that edge.
REQ-028: Reset asserted in ADD or DONE SHALL abort the operation; no out_valid for the aborted operands.

Configuration
REQ-029: With SERIAL_ADDER_SUB_EN defined, the sub port SHALL exist; sub=1 SHALL compute A + ~B + 1 (cin ignored), so cout = NOT borrow and ovf is signed subtract overflow; sub=0 SHALL behave as an add.
REQ-030: Without SERIAL_ADDER_SUB_EN, the sub port and its logic SHALL be absent and the block SHALL always add A + B + cin.

Verification
REQ-031: WIDTH=8, CHUNK=2, a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid exactly 4 edges after accept, sum=0x96, cout=0, ovf=1.
REQ-032: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-033: Back-to-back operation with out_ready held low for 5 cycles in DONE -> sum stable, in_ready=0, and a pulsed in_valid is ignored; the next accept is possible only the cycle after the handoff.
REQ-034: rst pulsed for 1 cycle at k=2 -> no out_valid follows, all outputs 0, in_ready=1; a new operation then completes correctly.
REQ-035: SERIAL_ADDER_SUB_EN, sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0; a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-036: WIDTH=1, CHUNK=1, a=1, b=1, cin=0 -> sum=0, cout=1 one edge after accept; exhaustive random compare against a + b + cin for WIDTH=16, CHUNK=4.
